// File: rtl/pmem_responder.sv
// pmem_responder: synthesizable fixed-latency 256-bit line memory for the mp3 pmem interface.
// Define PMEM_WRITE_MONITOR_EN to add the mon_write/mon_address/mon_wdata write-visibility outputs.
module pmem_responder #(
  parameter int ADDR_LINES_LOG2 = 10,
  parameter int LATENCY         = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         read,
  input  logic         write,
  input  logic [31:0]  address,
  input  logic [255:0] wdata,
  output logic         resp,
  output logic [255:0] rdata,
  output logic         error
`ifdef PMEM_WRITE_MONITOR_EN
  ,
  output logic         mon_write,
  output logic [26:0]  mon_address,
  output logic [255:0] mon_wdata
`endif
);

  localparam int         LINES  = 1 << ADDR_LINES_LOG2;
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                     state;
  state_t                     state_next;
  logic [7:0]                 count;
  logic                       op_write;
  logic [ADDR_LINES_LOG2-1:0] line_q;
  logic [255:0]               wdata_q;
  logic                       accept;
  logic                       illegal;
  logic                       commit;
  logic [255:0]               mem [LINES];
  logic                       unused_addr_bits;

  // Offset bits and bits above the line index are deliberately ignored (aliasing).
  assign unused_addr_bits = ^{address[31:5+ADDR_LINES_LOG2], address[4:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    illegal    = 1'b0;
    commit     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (read ^ write) begin
          accept     = 1'b1;
          state_next = ST_WAIT;
        end else if (read && write) begin
          illegal = 1'b1;
        end
      end
      ST_WAIT: begin
        if (count == 8'd0) begin
          commit     = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign resp = (state == ST_RESP);

  // Request fields are captured once at acceptance; later input changes do not matter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= '0;
      op_write <= 1'b0;
      line_q   <= '0;
      wdata_q  <= '0;
      error    <= 1'b0;
      rdata    <= '0;
    end else begin
      error <= illegal;
      if (accept) begin
        count    <= LAT_M1;
        op_write <= write;
        line_q   <= address[5+ADDR_LINES_LOG2-1:5];
        wdata_q  <= wdata;
      end else if (state == ST_WAIT && count != 8'd0) begin
        count <= count - 8'd1;
      end
      if (commit && !op_write) begin
        rdata <= mem[line_q];
      end
    end
  end

  // The array has no reset; reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst_n && commit && op_write) begin
      mem[line_q] <= wdata_q;
    end
  end

`ifdef PMEM_WRITE_MONITOR_EN
  logic [26:0] addr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (accept) begin
      addr_q <= address[31:5];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mon_write   <= 1'b0;
      mon_address <= '0;
      mon_wdata   <= '0;
    end else if (commit && op_write) begin
      mon_write   <= 1'b1;
      mon_address <= addr_q;
      mon_wdata   <= wdata_q;
    end else begin
      mon_write   <= 1'b0;
      mon_address <= '0;
      mon_wdata   <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Self-checking bench for pmem_responder: table vectors, corner-case sequences and a random
// phase checked against a line-array reference model.
`timescale 1ns/1ps
module tb_pmem_responder;

  localparam int ADDR_LINES_LOG2 = 10;
  localparam int LATENCY         = 4;
  localparam int LINES           = 1 << ADDR_LINES_LOG2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         read;
  logic         write;
  logic [31:0]  address;
  logic [255:0] wdata;
  logic         resp;
  logic [255:0] rdata;
  logic         error;
`ifdef PMEM_WRITE_MONITOR_EN
  logic         mon_write;
  logic [26:0]  mon_address;
  logic [255:0] mon_wdata;
`endif

  always #5 clk = ~clk;

  pmem_responder #(
    .ADDR_LINES_LOG2(ADDR_LINES_LOG2),
    .LATENCY        (LATENCY)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .read   (read),
    .write  (write),
    .address(address),
    .wdata  (wdata),
    .resp   (resp),
    .rdata  (rdata),
    .error  (error)
`ifdef PMEM_WRITE_MONITOR_EN
    ,
    .mon_write  (mon_write),
    .mon_address(mon_address),
    .mon_wdata  (mon_wdata)
`endif
  );

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
    logic [255:0] exp_rdata;
  } vec_t;

  int           checks = 0;
  int           errors = 0;
  logic [255:0] model_mem [LINES];
  bit           known [LINES];
  logic [255:0] model_rdata;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [255:0] data);
    read    = rd;
    write   = wr;
    address = addr;
    wdata   = data;
  endtask

  function automatic int line_of(input logic [31:0] addr);
    return int'((addr / 32) % LINES);
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Runs one request from an IDLE cycle; returns edges-to-resp (-1 on timeout) and rdata at resp.
  task automatic transact(input logic wr, input logic [31:0] addr, input logic [255:0] data,
                          input int drop_at, input logic [31:0] drop_addr,
                          output int lat, output logic [255:0] got);
    bit saw_error;
    saw_error = 1'b0;
    lat = -1;
    got = '0;
    applyStimulus(!wr, wr, addr, data);
    for (int n = 1; n <= LATENCY + 20; n++) begin
      step();
      if (error) saw_error = 1'b1;
      if (resp) begin
        lat = n;
        got = rdata;
`ifdef PMEM_WRITE_MONITOR_EN
        checkOutput("mon_write", 256'(mon_write), 256'(wr));
        checkOutput("mon_address", 256'(mon_address), wr ? 256'(addr[31:5]) : 256'(0));
        checkOutput("mon_wdata", mon_wdata, wr ? data : 256'(0));
`endif
        break;
      end
      if (n == drop_at) applyStimulus(1'b0, 1'b0, drop_addr, ~data);
    end
    applyStimulus(1'b0, 1'b0, addr, data);
    checkOutput("error_quiet", 256'(saw_error), 256'(0));
    step();
    checkOutput("resp_single_pulse", 256'(resp), 256'(0));
  endtask

  task automatic model_txn(input logic wr, input logic [31:0] addr, input logic [255:0] data,
                           input int drop_at, input logic [31:0] drop_addr, input string tag);
    int           lat;
    logic [255:0] got;
    int           ln;
    ln = line_of(addr);
    transact(wr, addr, data, drop_at, drop_addr, lat, got);
    if (wr) begin
      model_mem[ln] = data;
      known[ln]     = 1'b1;
    end else if (known[ln]) begin
      model_rdata = model_mem[ln];
    end
    checkOutput({tag, "_latency"}, 256'(lat), 256'(LATENCY + 1));
    if (wr || known[ln]) checkOutput({tag, "_rdata"}, got, model_rdata);
  endtask

  initial begin
    vec_t         vecs [9];
    logic [255:0] a5;
    logic [255:0] p;
    logic [255:0] q;
    logic [255:0] got;
    logic [255:0] d;
    int           lat;
    int           first;
    int           second;
    bit           saw;

    a5 = {8{32'hA5A5_A5A5}};
    p  = {8{32'hDEAD_BEEF}};
    q  = {4{64'h0123_4567_89AB_CDEF}};
    vecs[0] = '{1'b1, 32'h0000_0040, a5,      256'(0)};
    vecs[1] = '{1'b0, 32'h0000_0047, '0,      a5};
    vecs[2] = '{1'b1, 32'h0000_0020, 256'(1), a5};
    vecs[3] = '{1'b0, 32'h0000_8020, '0,      256'(1)};
    vecs[4] = '{1'b1, 32'h0000_1000, p,       256'(1)};
    vecs[5] = '{1'b0, 32'h0000_101F, '0,      p};
    vecs[6] = '{1'b1, 32'h0000_0040, q,       p};
    vecs[7] = '{1'b0, 32'h0000_8040, '0,      q};
    vecs[8] = '{1'b0, 32'hFFFF_8020, '0,      256'(1)};
    for (int i = 0; i < LINES; i++) known[i] = 1'b0;
    model_rdata = '0;

    // Reset held two cycles with a read pending: all outputs quiet, then a normal response.
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0, '0);
    for (int c = 0; c < 2; c++) begin
      step();
      checkOutput("reset_resp", 256'(resp), 256'(0));
      checkOutput("reset_rdata", rdata, 256'(0));
      checkOutput("reset_error", 256'(error), 256'(0));
    end
    rst_n = 1'b1;
    lat = -1;
    for (int n = 1; n <= LATENCY + 20; n++) begin
      step();
      if (resp) begin
        lat = n;
        break;
      end
    end
    applyStimulus(1'b0, 1'b0, 32'h0, '0);
    checkOutput("reset_release_latency", 256'(lat), 256'(LATENCY + 1));
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checkOutput("rereset_rdata", rdata, 256'(0));

    $display("[TB] table vectors");
    for (int i = 0; i < 9; i++) begin
      transact(vecs[i].wr, vecs[i].addr, vecs[i].data, 0, 32'h0, lat, got);
      checkOutput($sformatf("vec%0d_latency", i), 256'(lat), 256'(LATENCY + 1));
      checkOutput($sformatf("vec%0d_rdata", i), got, vecs[i].exp_rdata);
      if (vecs[i].wr) begin
        model_mem[line_of(vecs[i].addr)] = vecs[i].data;
        known[line_of(vecs[i].addr)]     = 1'b1;
      end else begin
        model_rdata = vecs[i].exp_rdata;
      end
    end

    for (int ln = 0; ln < 16; ln++) model_txn(1'b1, 32'(ln * 32), rand_line(), 0, 32'h0, "prewrite");

    $display("[TB] illegal request");
    applyStimulus(1'b1, 1'b1, 32'h0000_0040, ~model_mem[2]);
    for (int c = 1; c <= 3; c++) begin
      step();
      checkOutput("illegal_error_high", 256'(error), 256'(1));
      checkOutput("illegal_no_resp", 256'(resp), 256'(0));
    end
    applyStimulus(1'b0, 1'b0, 32'h0, '0);
    step();
    checkOutput("illegal_error_low", 256'(error), 256'(0));
    saw = 1'b0;
    for (int c = 0; c < LATENCY + 3; c++) begin
      step();
      if (resp) saw = 1'b1;
    end
    checkOutput("illegal_never_resp", 256'(saw), 256'(0));
    model_txn(1'b0, 32'h0000_0040, '0, 0, 32'h0, "illegal_readback");

    $display("[TB] mid-flight drop and held request");
    model_txn(1'b0, 32'h0000_00A0, '0, 1, 32'h0000_00C0, "drop");
    applyStimulus(1'b1, 1'b0, 32'h0000_00C0, '0);
    first  = -1;
    second = -1;
    for (int n = 1; n <= 3 * (LATENCY + 2); n++) begin
      step();
      if (resp) begin
        if (first < 0) begin
          first = n;
        end else begin
          second = n;
          got    = rdata;
          applyStimulus(1'b0, 1'b0, 32'h0, '0);
          break;
        end
      end
    end
    applyStimulus(1'b0, 1'b0, 32'h0, '0);
    step();
    checkOutput("held_first_latency", 256'(first), 256'(LATENCY + 1));
    checkOutput("held_spacing", 256'(second - first), 256'(LATENCY + 2));
    checkOutput("held_rdata", got, model_mem[6]);
    model_rdata = model_mem[6];

    $display("[TB] reset aborts");
    for (int k = 0; k < 2; k++) begin
      d = rand_line();
      applyStimulus(1'b0, 1'b1, 32'h0000_00E0, d);
      for (int c = 0; c < ((k == 0) ? 2 : LATENCY); c++) step();
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0, '0);
      step();
      rst_n = 1'b1;
      saw = resp;
      for (int c = 0; c < LATENCY + 3; c++) begin
        step();
        if (resp) saw = 1'b1;
      end
      checkOutput($sformatf("abort%0d_no_resp", k), 256'(saw), 256'(0));
      checkOutput($sformatf("abort%0d_rdata_reset", k), rdata, 256'(0));
      model_rdata = '0;
      model_txn(1'b0, 32'h0000_00E0, '0, 0, 32'h0, "abort_readback");
    end

    $display("[TB] random phase");
    for (int t = 0; t < 40; t++) begin
      logic [31:0] addr;
      addr = ($urandom() & 32'hFFFF_8000) | 32'($urandom_range(0, 15) * 32)
             | 32'($urandom_range(0, 31));
      model_txn(1'($urandom_range(0, 1)), addr, rand_line(), 0, 32'h0, "random");
      for (int c = 0; c < int'($urandom_range(0, 2)); c++) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmem_responder.md
# pmem_responder

Synthesizable responder for the 256-bit physical-memory line interface driven by the `mp3` cache hierarchy (`pmem_read`/`pmem_write`/`pmem_address`/`pmem_wdata` in, `pmem_resp`/`pmem_rdata` out). It holds a line-addressed backing store, accepts one line read or write at a time, and answers after a programmable fixed latency. It replaces the behavioural `physical_memory` model wherever a synthesizable memory end is needed, such as FPGA bring-up or latency sweeps.

## Interface
- `ADDR_LINES_LOG2`, default 10: log2 of the number of 32-byte lines stored (1024 lines, 32 KiB).
- `LATENCY`, default 8: wait cycles before a response. Legal range is 1..255.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `read`  in  1  line read request; held by the requester until `resp`.
- `write`  in  1  line write request; held by the requester until `resp`.
- `address`  in  32  byte address. Bits [4:0] are ignored.
- `wdata`  in  256  write line.
- `resp`  out  1  single-cycle completion pulse.
- `rdata`  out  256  read line; valid while `resp` is high after a read.
- `error`  out  1  single-cycle pulse when `read` and `write` are both high in IDLE.
- `mon_write`, `mon_address[26:0]`, `mon_wdata[255:0]`  out. These exist only under `PMEM_WRITE_MONITOR_EN`.

## Operation
- Line index is `address[5+ADDR_LINES_LOG2-1:5]`. Address bits above the index are ignored, so higher addresses alias onto stored lines.
- FSM states:
  - **IDLE**
    - If exactly one of `read`/`write` is high: latch op, index, `wdata`, and full `address[31:5]`; load counter with LATENCY-1; go to WAIT.
    - If both are high: pulse `error`, accept nothing, stay in IDLE.
    - If neither is high: stay in IDLE.
  - **WAIT**
    - If counter is 0: go to RESP. For a write, commit the latched `wdata` to the array on this edge. For a read, load `rdata` from the array on this edge.
    - Otherwise decrement the counter.
  - **RESP**
    - Drive `resp`=1 for exactly this cycle.
    - Return to IDLE unconditionally.
- Latched request fields are authoritative. Changes on `address`/`wdata` after acceptance are ignored.
- If the request is dropped mid-flight, the transaction still completes and `resp` still pulses.
- The IDLE cycle after RESP re-samples the inputs. A request still held there is a new transaction.
- `rdata` holds its last read value across writes and idle periods. It changes only on read completion.
- Read-after-write to the same line returns the written data, because the commit precedes any later acceptance.
- One transaction is outstanding at a time. There is no queueing.

## Timing
- Reset values: FSM in IDLE, counter 0, `resp`=0, `error`=0, `rdata`=0, monitor outputs 0.
- The array is not cleared by reset.
- Reset asserted mid-transaction aborts it:
  - no `resp` pulse;
  - no array write, unless the commit edge itself coincides with the first reset cycle, in which case reset wins and no write occurs.
- Request first high in cycle 0 (FSM in IDLE): `resp` is high in cycle LATENCY+1.
- With LATENCY=1, `resp` is high in cycle 2.
- Minimum spacing between back-to-back transactions with a continuously held request is LATENCY+2 cycles.
- `error` is high in the cycle after the illegal request was sampled. It repeats every cycle while the condition persists.

## Configuration
- `PMEM_WRITE_MONITOR_EN` defined:
  - Adds `mon_write`, `mon_address`, and `mon_wdata`.
  - `mon_write` pulses concurrently with `resp` for write transactions only.
  - `mon_address` and `mon_wdata` carry the latched `address[31:5]` and `wdata` during that pulse, and are 0 otherwise.
  - This gives the same write visibility the autograder checker uses.
- `PMEM_WRITE_MONITOR_EN` undefined: these ports and their registers are absent. Nothing else changes.

## Test plan
- Reset check, LATENCY=4: hold `rst_n`=0 for 2 cycles with `read`=1 → `resp`=0, `rdata`=0, `error`=0 throughout. After release, `resp` pulses exactly 5 cycles later.
- Write then read, LATENCY=4:
  - write `wdata`=256'hA5…A5 to `address`=0x0000_0040;
  - then read 0x0000_0047;
  - → each `resp` arrives 5 cycles after its request, and `rdata`=256'hA5…A5.
- Alias, ADDR_LINES_LOG2=10:
  - write 256'h1 to 0x0000_0020;
  - read 0x0000_8020;
  - → `rdata`=256'h1.
- Illegal request: `read`=`write`=1 for 3 cycles → `error` high for 3 cycles starting one cycle later, no `resp`, array unchanged (verify with a subsequent read).
- Mid-flight drop:
  - drop `read` after 1 cycle and change `address`;
  - → `resp` is still at cycle LATENCY+1, with data from the originally latched line;
  - held `read` after `resp` → a second `resp` arrives at LATENCY+2 cycles spacing.
- Monitor (macro defined): write 0x0000_1000 → `mon_write`=1 coincident with `resp`, `mon_address`=27'h80, `mon_wdata` equals the written line. A read produces no `mon_write` pulse.
